// File: rtl/ledr_sequencer.sv
// ledr_sequencer: Avalon-MM programmable LED pattern sequencer.
// Steps through up to DEPTH stored patterns on out_port. Each pattern is held
// for PERIOD cycles. The sequence either stops after the last entry (setting
// done) or loops back to the first entry.
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   address, chipselect,
//   write_n, writedata    - Avalon-MM slave write side
//   readdata              - combinational register read mux
//   out_port              - registered LED pattern drive
//   irq                   - registered level interrupt (done & irq_en)
module ledr_sequencer #(
  parameter int unsigned DATA_WIDTH   = 18,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned PERIOD_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic                    ctrl_run, ctrl_loop, ctrl_irq_en;
  logic                    done;
  logic [IDX_W-1:0]        idx;
  logic [PERIOD_WIDTH-1:0] period_reg;
  logic [3:0]              length_reg;
  logic [PERIOD_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0]   pattern [DEPTH];

  // Bus decode
  logic             wr, wr_ctrl, wr_status, wr_period, wr_length, pat_sel;
  logic [IDX_W-1:0] pat_idx;
  logic             unused_wdata;

  assign wr        = chipselect && !write_n;
  assign wr_ctrl   = wr && (address == 4'd0);
  assign wr_status = wr && (address == 4'd1);
  assign wr_period = wr && (address == 4'd2);
  assign wr_length = wr && (address == 4'd3);
  assign pat_sel   = address[3] && (32'(address[2:0]) < DEPTH);
  assign pat_idx   = address[IDX_W-1:0];
  assign unused_wdata = ^writedata;

  // Effective period/length after clamping
  logic [PERIOD_WIDTH-1:0] eff_period;
  logic [3:0]              eff_len;
  logic                    step_end, last_step;

  assign eff_period = (period_reg == '0) ? PERIOD_WIDTH'(1) : period_reg;
  assign eff_len    = (length_reg == 4'd0)          ? 4'd1 :
                      (32'(length_reg) > DEPTH)     ? 4'(DEPTH) : length_reg;
  assign step_end   = (cnt == PERIOD_WIDTH'(1));
  // >= so a LENGTH shrunk below the current index ends the pass cleanly
  assign last_step  = (4'(idx) >= (eff_len - 4'd1));

  // Sequencer control
  logic             load, finish;
  logic [IDX_W-1:0] load_idx;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state; a CTRL write outranks a coincident step end
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    load_idx  = '0;
    case (state)
      S_IDLE: begin
        if (wr_ctrl && writedata[0]) begin
          state_nxt = S_RUN;
          load      = 1'b1;
        end
      end
      S_RUN: begin
        if (wr_ctrl) begin
          if (writedata[0]) load = 1'b1;
          else              state_nxt = S_IDLE;
        end else if (step_end) begin
          if (!last_step) begin
            load     = 1'b1;
            load_idx = idx + IDX_W'(1);
          end else if (ctrl_loop) begin
            load = 1'b1;
          end else begin
            state_nxt = S_IDLE;
            finish    = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registers, pattern store and output drive
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_run    <= 1'b0;
      ctrl_loop   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      done        <= 1'b0;
      idx         <= '0;
      period_reg  <= '0;
      length_reg  <= '0;
      cnt         <= '0;
      out_port    <= '0;
      irq         <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) pattern[i] <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_run    <= writedata[0];
        ctrl_loop   <= writedata[1];
        ctrl_irq_en <= writedata[2];
      end else if (finish) begin
        ctrl_run <= 1'b0;
      end

      // Completion beats a simultaneous clear
      if (finish)                         done <= 1'b1;
      else if (wr_status && writedata[1]) done <= 1'b0;

      if (wr_period)      period_reg <= writedata[PERIOD_WIDTH-1:0];
      if (wr_length)      length_reg <= writedata[3:0];
      if (wr && pat_sel)  pattern[pat_idx] <= writedata[DATA_WIDTH-1:0];

      if (load) begin
        idx      <= load_idx;
        out_port <= pattern[load_idx];
        cnt      <= eff_period;
      end else if (state == S_RUN) begin
        cnt <= cnt - PERIOD_WIDTH'(1);
      end

      irq <= done && ctrl_irq_en;
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    readdata = '0;
    if (pat_sel) begin
      readdata = 32'(pattern[pat_idx]);
    end else begin
      case (address)
        4'd0:    readdata = {29'd0, ctrl_irq_en, ctrl_loop, ctrl_run};
        4'd1:    readdata = {25'd0, 3'(idx), 2'b00, done, (state == S_RUN)};
        4'd2:    readdata = 32'(period_reg);
        4'd3:    readdata = {28'd0, length_reg};
        default: readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ledr_sequencer.sv
// Self-checking bench for ledr_sequencer: directed scenarios plus randomized
// runs compared against a timeline model derived from period/length arithmetic.
module tb_ledr_sequencer;
  localparam int unsigned DW = 18, DEPTH = 8, PW = 24;

  logic          clk = 1'b0, reset = 1'b1;
  logic [3:0]    address = '0;
  logic          chipselect = 1'b0, write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [DW-1:0] out_port;
  logic          irq;

  int n_checks = 0, n_fail = 0;

  // Shadow of programmed values
  logic [DW-1:0] m_pat [DEPTH];
  int            m_period, m_length;

  ledr_sequencer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PERIOD_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_port(out_port), .irq(irq));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    address = 4'(a); writedata = d; chipselect = 1'b1; write_n = 1'b0;
    cyc();
    chipselect = 1'b0; write_n = 1'b1;
    if (a == 2) m_period = int'(d[PW-1:0]);
    if (a == 3) m_length = int'(d[3:0]);
    if (a >= 8 && a < 8 + DEPTH) m_pat[a-8] = d[DW-1:0];
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    address = 4'(a); chipselect = 1'b1; write_n = 1'b1;
    #1 d = readdata;
    chipselect = 1'b0;
  endtask

  function automatic int eff_p();
    return (m_period == 0) ? 1 : m_period;
  endfunction

  function automatic int eff_l();
    if (m_length == 0) return 1;
    return (m_length > DEPTH) ? DEPTH : m_length;
  endfunction

  task automatic model_reset();
    m_period = 0; m_length = 0;
    for (int i = 0; i < DEPTH; i++) m_pat[i] = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; cyc(); cyc(); reset = 1'b0;
    model_reset();
    n_checks++; if (out_port !== '0) begin n_fail++; $display("FAIL reset_out got %h exp 0", out_port); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", irq); end
    for (int a = 0; a < 16; a++) begin
      rd(a, d);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reset_reg a=%0d got %h exp 0", a, d); end
      cyc();
    end
  endtask

  task automatic test_one_shot();
    logic [31:0] d;
    logic [DW-1:0] e;
    wr(2, 3); wr(3, 2); wr(8, 1); wr(9, 2); wr(0, 1);
    for (int t = 0; t < 9; t++) begin
      e = (t < 3) ? DW'(1) : DW'(2);
      n_checks++; if (out_port !== e) begin n_fail++; $display("FAIL one_shot_out t=%0d got %h exp %h", t, out_port, e); end
      rd(1, d);
      n_checks++; if (d[0] !== (t < 6)) begin n_fail++; $display("FAIL one_shot_busy t=%0d got %b exp %b", t, d[0], t < 6); end
      cyc();
    end
    rd(1, d);
    n_checks++; if (d !== 32'h12) begin n_fail++; $display("FAIL one_shot_status got %h exp 12", d); end
    rd(0, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL one_shot_ctrl got %h exp 0", d); end
  endtask

  task automatic test_loop();
    logic [31:0] d;
    logic [DW-1:0] e;
    wr(1, 2); wr(0, 3);
    for (int t = 0; t < 14; t++) begin
      e = (((t / 3) % 2) == 1) ? DW'(2) : DW'(1);
      n_checks++; if (out_port !== e) begin n_fail++; $display("FAIL loop_out t=%0d got %h exp %h", t, out_port, e); end
      rd(1, d);
      n_checks++; if (d[1:0] !== 2'b01) begin n_fail++; $display("FAIL loop_status t=%0d got %b exp 01", t, d[1:0]); end
      if (t < 13) cyc();
    end
    wr(0, 0);
    n_checks++; if (out_port !== DW'(1)) begin n_fail++; $display("FAIL loop_stop_out got %h exp 1", out_port); end
    rd(1, d);
    n_checks++; if (d[1:0] !== 2'b00) begin n_fail++; $display("FAIL loop_stop_status got %b exp 00", d[1:0]); end
  endtask

  task automatic test_min_period();
    logic [31:0] d;
    wr(1, 2); wr(2, 0); wr(3, 0); wr(8, $urandom); wr(0, 1);
    for (int t = 0; t < 3; t++) begin
      n_checks++; if (out_port !== m_pat[0]) begin n_fail++; $display("FAIL minp_out t=%0d got %h exp %h", t, out_port, m_pat[0]); end
      rd(1, d);
      n_checks++; if (d[1:0] !== ((t == 0) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL minp_status t=%0d got %b", t, d[1:0]); end
      cyc();
    end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    wr(1, 2); wr(2, 2); wr(3, 1); wr(0, 5);
    for (int t = 0; t < 5; t++) begin
      n_checks++; if (irq !== (t >= 3)) begin n_fail++; $display("FAIL irq_rise t=%0d got %b exp %b", t, irq, t >= 3); end
      rd(1, d);
      n_checks++; if (d[1] !== (t >= 2)) begin n_fail++; $display("FAIL irq_done t=%0d got %b exp %b", t, d[1], t >= 2); end
      cyc();
    end
    wr(1, 2);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_lag got %b exp 1", irq); end
    cyc();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b exp 0", irq); end
    // Clear lands on the completion edge: set must win
    wr(0, 5); cyc(); wr(1, 2);
    rd(1, d);
    n_checks++; if (d[1] !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins got %b exp 1", d[1]); end
    cyc();
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_after_race got %b exp 1", irq); end
    wr(0, 0);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_en_lag got %b exp 1", irq); end
    cyc();
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_en_off got %b exp 0", irq); end
  endtask

  task automatic test_stop_mid();
    logic [31:0] d;
    logic [DW-1:0] e, old1;
    wr(1, 2); wr(2, 4); wr(3, 3);
    for (int i = 0; i < 3; i++) wr(8 + i, $urandom);
    old1 = m_pat[1];
    wr(0, 1);
    for (int t = 0; t < 5; t++) begin
      e = (t < 4) ? m_pat[0] : m_pat[1];
      n_checks++; if (out_port !== e) begin n_fail++; $display("FAIL stop_seq t=%0d got %h exp %h", t, out_port, e); end
      cyc();
    end
    wr(9, $urandom);
    n_checks++; if (out_port !== old1) begin n_fail++; $display("FAIL stop_midwrite got %h exp %h", out_port, old1); end
    wr(0, 0);
    rd(1, d);
    n_checks++; if (d[6:0] !== 7'h10) begin n_fail++; $display("FAIL stop_status got %h exp 10", d[6:0]); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (out_port !== old1) begin n_fail++; $display("FAIL stop_hold k=%0d got %h exp %h", k, out_port, old1); end
      cyc();
    end
    wr(9, $urandom);
    n_checks++; if (out_port !== old1) begin n_fail++; $display("FAIL idle_patwrite got %h exp %h", out_port, old1); end
    wr(0, 1);
    n_checks++; if (out_port !== m_pat[0]) begin n_fail++; $display("FAIL restart_p0 got %h exp %h", out_port, m_pat[0]); end
    for (int k = 0; k < 4; k++) cyc();
    n_checks++; if (out_port !== m_pat[1]) begin n_fail++; $display("FAIL restart_newp1 got %h exp %h", out_port, m_pat[1]); end
    wr(0, 0);
  endtask

  task automatic test_period_midrun();
    logic [31:0] d;
    logic [DW-1:0] e;
    wr(1, 2); wr(2, 3); wr(3, 2); wr(0, 1);
    wr(2, 5);
    for (int t = 1; t < 10; t++) begin
      e = (t < 3) ? m_pat[0] : m_pat[1];
      n_checks++; if (out_port !== e) begin n_fail++; $display("FAIL period_mid_out t=%0d got %h exp %h", t, out_port, e); end
      rd(1, d);
      n_checks++; if (d[0] !== (t < 8)) begin n_fail++; $display("FAIL period_mid_busy t=%0d got %b exp %b", t, d[0], t < 8); end
      cyc();
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [6:0]  es;
    logic        lp, en, eb, ed, ei;
    int          p, l, n, step, ix;
    for (int it = 0; it < 8; it++) begin
      wr(1, 2);
      wr(2, {8'($urandom), 24'($urandom_range(0, 4))});
      wr(3, {28'($urandom), 4'($urandom_range(0, 10))});
      for (int i = 0; i < DEPTH; i++) wr(8 + i, $urandom);
      lp = 1'($urandom); en = 1'($urandom);
      p = eff_p(); l = eff_l();
      wr(0, {29'd0, en, lp, 1'b1});
      n = lp ? 2 * l * p + 2 : l * p + 3;
      for (int t = 0; t < n; t++) begin
        step = t / p;
        if (lp)            begin ix = step % l; eb = 1'b1; ed = 1'b0; end
        else if (step < l) begin ix = step;     eb = 1'b1; ed = 1'b0; end
        else               begin ix = l - 1;    eb = 1'b0; ed = 1'b1; end
        ei = en && !lp && (t >= 1) && (t - 1 >= l * p);
        es = {3'(ix), 2'b00, ed, eb};
        n_checks++; if (out_port !== m_pat[ix]) begin n_fail++; $display("FAIL rand_out it=%0d t=%0d got %h exp %h", it, t, out_port, m_pat[ix]); end
        n_checks++; if (irq !== ei) begin n_fail++; $display("FAIL rand_irq it=%0d t=%0d got %b exp %b", it, t, irq, ei); end
        rd(1, d);
        n_checks++; if (d[6:0] !== es) begin n_fail++; $display("FAIL rand_status it=%0d t=%0d got %h exp %h", it, t, d[6:0], es); end
        cyc();
      end
      if (lp) wr(0, 0);
      rd(0, d);
      n_checks++; if (d !== (lp ? 32'h0 : {29'd0, en, lp, 1'b0})) begin n_fail++; $display("FAIL rand_ctrl it=%0d got %h", it, d); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    wr(1, 2); wr(2, 2); wr(3, 1); wr(0, 5);
    for (int k = 0; k < 3; k++) cyc();
    wr(0, 7); cyc();
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_irq got %b exp 1", irq); end
    reset = 1'b1;
    address = 4'd0; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
    cyc();
    chipselect = 1'b0; write_n = 1'b1; reset = 1'b0;
    model_reset();
    n_checks++; if (out_port !== '0) begin n_fail++; $display("FAIL rstmid_out got %h exp 0", out_port); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rstmid_irq got %b exp 0", irq); end
    for (int a = 0; a < 16; a++) begin
      rd(a, d);
      n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rstmid_reg a=%0d got %h exp 0", a, d); end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_loop();
    test_min_period();
    test_irq();
    test_stop_mid();
    test_period_midrun();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
